// File: rtl/sort_dedup_engine.sv
// sort_dedup_engine: accepts a vector of N unsigned elements, sorts it ascending
// with an odd-even transposition network (one phase per cycle), optionally
// compacts out duplicates (one element per cycle), then presents the result
// until the consumer takes it. Latency is fixed: N edges (sort only) or 2N
// edges (sort + dedup) from acceptance to out_valid.
module sort_dedup_engine #(
    parameter int DATA_W = 8,
    parameter int N      = 9,
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                dedup_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]    unique_count
);

    typedef enum logic [1:0] {IDLE, SORT, DEDUP, DONE} state_t;

    state_t                   state, state_nxt;
    logic [N-1:0][DATA_W-1:0] work;       // working array, also holds the result
    logic [N-1:0][DATA_W-1:0] sorted;     // work after the current sort phase
    logic [CNT_W-1:0]         cnt;        // phase index in SORT, scan index in DEDUP
    logic [CNT_W-1:0]         ucnt;       // kept-element count / write pointer
    logic [DATA_W-1:0]        last;       // last kept value during the dedup scan
    logic                     dd;         // dedup_en latched at acceptance
    logic                     last_step;
    logic                     keep;

    assign last_step = (cnt == CNT_W'(N - 1));
    assign keep      = (cnt == '0) || (work[cnt] != last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: fixed phase counts make latency data-independent
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SORT;
            SORT:    if (last_step) state_nxt = dd ? DEDUP : DONE;
            DEDUP:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: result is only exposed in DONE so aborted runs never leak
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        out_data     = (state == DONE) ? work : '0;
        unique_count = (state == DONE) ? ucnt : '0;
    end

    // One odd-even transposition phase; pairs are disjoint so all swaps are parallel
    always_comb begin
        sorted = work;
        for (int k = 0; k < N - 1; k++) begin
            if (((k % 2) == int'(cnt[0])) && (work[k] > work[k+1])) begin
                sorted[k]   = work[k+1];
                sorted[k+1] = work[k];
            end
        end
    end

    // Datapath: latch, sort phases, then in-place dedup compaction.
    // During the scan slot i is zeroed and, if kept, work[i] is written to
    // slot ucnt (ucnt <= i). The later NBA wins when ucnt == i, and no slot
    // below ucnt is ever zeroed after being filled, so upper slots end at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            ucnt <= '0;
            last <= '0;
            dd   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        dd   <= dedup_en;
                        cnt  <= '0;
                        ucnt <= '0;
                    end
                end
                SORT: begin
                    work <= sorted;
                    cnt  <= last_step ? '0 : cnt + CNT_W'(1);
                    if (last_step && !dd) ucnt <= CNT_W'(N);
                end
                DEDUP: begin
                    work[cnt] <= '0;
                    if (keep) begin
                        work[ucnt] <= work[cnt];
                        last       <= work[cnt];
                        ucnt       <= ucnt + CNT_W'(1);
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_dedup_engine.sv
// Testbench for sort_dedup_engine (N=9, DATA_W=8): directed table, random
// vectors against a queue/array reference model, backpressure and mid-sort reset.
module tb_sort_dedup_engine;

    localparam int N      = 9;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int W      = N * DATA_W;

    logic             clk, rst_n;
    logic             in_valid, in_ready, dedup_en;
    logic [W-1:0]     in_data, out_data;
    logic             out_valid, out_ready;
    logic [CNT_W-1:0] unique_count;

    int  checks   = 0;
    int  errors   = 0;
    bit  busy_bad = 0;

    sort_dedup_engine #(.DATA_W(DATA_W), .N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dedup_en(dedup_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .unique_count(unique_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic         dd;
        logic [W-1:0] exp;
        int           cnt;
        int           lat;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int a[N]);
        logic [W-1:0] o;
        o = '0;
        for (int k = 0; k < N; k++) o[k*DATA_W +: DATA_W] = a[k][DATA_W-1:0];
        return o;
    endfunction

    // Reference: plain sort, then keep distinct values in ascending order
    task automatic model(input logic [W-1:0] d, input logic dd,
                         output logic [W-1:0] o, output int c);
        int a[N];
        int u[$];
        int t;
        for (int k = 0; k < N; k++) a[k] = int'(d[k*DATA_W +: DATA_W]);
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        if (!dd) begin
            o = pack(a);
            c = N;
        end else begin
            u.delete();
            for (int k = 0; k < N; k++)
                if (u.size() == 0 || u[u.size()-1] != a[k]) u.push_back(a[k]);
            c = u.size();
            for (int k = 0; k < N; k++) a[k] = (k < c) ? u[k] : 0;
            o = pack(a);
        end
    endtask

    task automatic accept(input logic [W-1:0] din, input logic dd);
        logic [95:0] r;
        @(negedge clk);
        chk("accept_in_ready", W'(in_ready), W'(1));
        in_valid = 1; in_data = din; dedup_en = dd;
        @(posedge clk); #1;
        r = {$urandom(), $urandom(), $urandom()};
        in_valid = 0; in_data = r[W-1:0]; dedup_en = ~dd;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
            if (in_ready) busy_bad = 1;
        end
        if (lat < 0) $display("FAIL wait_out: out_valid not seen within 60 edges");
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("release_out_valid", W'(out_valid), W'(0));
        chk("release_in_ready", W'(in_ready), W'(1));
    endtask

    task automatic run_vec(input string nm, input logic [W-1:0] din, input logic dd,
                           input logic [W-1:0] exp, input int ecnt, input int elat);
        int lat;
        accept(din, dd);
        wait_out(lat);
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_count"}, W'(unique_count), W'(ecnt));
        chk({nm, "_latency"}, W'(lat), W'(elat));
        release_out();
    endtask

    initial begin
        vec_t         tv[7];
        int           a[N];
        int           mc, lat;
        logic [W-1:0] me, d, hold;
        logic         rdd;

        a = '{5,3,9,3,1,9,7,5,2};           tv[0].din = pack(a);
        a = '{1,2,3,5,7,9,0,0,0};           tv[0].exp = pack(a);
        tv[0].dd = 1; tv[0].cnt = 6; tv[0].lat = 2*N;
        tv[1].din = tv[0].din;
        a = '{1,2,3,3,5,5,7,9,9};           tv[1].exp = pack(a);
        tv[1].dd = 0; tv[1].cnt = 9; tv[1].lat = N;
        a = '{255,255,255,255,255,255,255,255,255}; tv[2].din = pack(a); tv[6].din = pack(a);
        tv[6].exp = pack(a);
        tv[6].dd = 0; tv[6].cnt = 9; tv[6].lat = N;
        a = '{255,0,0,0,0,0,0,0,0};         tv[2].exp = pack(a);
        tv[2].dd = 1; tv[2].cnt = 1; tv[2].lat = 2*N;
        tv[3].din = '0; tv[3].exp = '0; tv[3].dd = 1; tv[3].cnt = 1; tv[3].lat = 2*N;
        tv[4].din = '0; tv[4].exp = '0; tv[4].dd = 0; tv[4].cnt = 9; tv[4].lat = N;
        a = '{8,7,6,5,4,3,2,1,0};           tv[5].din = pack(a);
        a = '{0,1,2,3,4,5,6,7,8};           tv[5].exp = pack(a);
        tv[5].dd = 1; tv[5].cnt = 9; tv[5].lat = 2*N;

        clk = 0; rst_n = 0; in_valid = 0; in_data = '0; dedup_en = 0; out_ready = 0;
        #12;
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_data", out_data, '0);
        chk("reset_unique_count", W'(unique_count), W'(0));
        @(negedge clk); rst_n = 1;

        // Directed table
        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), tv[i].din, tv[i].dd, tv[i].exp, tv[i].cnt, tv[i].lat);

        // Random vectors: alternate narrow (many duplicates) and full-range values
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < N; k++)
                a[k] = (i % 2 == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255));
            d = pack(a);
            rdd = 1'($urandom_range(0, 1));
            model(d, rdd, me, mc);
            run_vec($sformatf("rand%0d", i), d, rdd, me, mc, rdd ? 2*N : N);
        end

        // Backpressure: new vector offered while DONE stalls must not be taken
        a = '{4,4,2,9,0,7,7,1,3}; d = pack(a);
        accept(d, 1);
        wait_out(lat);
        hold = out_data;
        model(d, 1, me, mc);
        chk("bp_first_data", hold, me);
        @(negedge clk);
        a = '{6,1,8,1,0,2,5,3,3};
        in_valid = 1; in_data = pack(a); dedup_en = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_stable%0d", c), out_data, hold);
            chk($sformatf("bp_in_ready%0d", c), W'(in_ready), W'(0));
            chk($sformatf("bp_out_valid%0d", c), W'(out_valid), W'(1));
        end
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        chk("bp_xfer_out_valid", W'(out_valid), W'(0));
        chk("bp_xfer_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 0; in_data = '1; dedup_en = 1;
        chk("bp_accepted", W'(in_ready), W'(0));
        wait_out(lat);
        model(pack(a), 0, me, mc);
        chk("bp_second_data", out_data, me);
        chk("bp_second_count", W'(unique_count), W'(mc));
        chk("bp_second_latency", W'(lat), W'(N));
        release_out();

        // Reset in the middle of SORT aborts with no partial result
        a = '{9,8,7,6,5,4,3,2,1}; accept(pack(a), 1);
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_out_valid", W'(out_valid), W'(0));
        chk("rst_mid_out_data", out_data, '0);
        chk("rst_mid_count", W'(unique_count), W'(0));
        chk("rst_mid_in_ready", W'(in_ready), W'(1));
        @(negedge clk); rst_n = 1;
        a = '{3,3,200,17,0,255,17,42,1}; d = pack(a);
        model(d, 1, me, mc);
        run_vec("post_reset", d, 1, me, mc, 2*N);

        chk("busy_in_ready_low", W'(busy_bad), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_dedup_engine.md
SORT_DEDUP_ENGINE -- requirements
Module: sort_dedup_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning element width in bits (1..32).
REQ-002 The block SHALL have parameter N, default 9, meaning elements per vector (2..16).
REQ-003 The block SHALL have parameter CNT_W, default $clog2(N+1), meaning unique_count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input vector valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-008 The block SHALL have port in_data, input, N*DATA_W bits: element k at bits [k*DATA_W +: DATA_W], unsigned.
REQ-009 The block SHALL have port dedup_en, input, 1 bit: 1 removes duplicates, 0 only sorts; sampled at acceptance.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, N*DATA_W bits: result, same packing as in_data.
REQ-013 The block SHALL have port unique_count, output, CNT_W bits: number of meaningful elements in out_data.

Function
REQ-014 The FSM SHALL have states IDLE, SORT, DEDUP and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance occurs on an edge with in_valid=1 and in_ready=1: in_data is latched into the working array, dedup_en is latched, and the FSM goes to SORT.
REQ-017 SORT SHALL perform ascending odd-even transposition sort, one phase per cycle, for exactly N cycles.
REQ-018 Phase p compares/swaps pairs (k,k+1) with k even when p is even and k odd when p is odd; the swap condition is strictly greater.
REQ-019 After N phases: if the latched dedup_en is 1, go to DEDUP; otherwise go to DONE with unique_count=N.
REQ-020 DEDUP SHALL scan the sorted array one element per cycle for N cycles.
REQ-021 DEDUP SHALL keep element 0 unconditionally; element i>0 is kept iff it differs from the last kept value.
REQ-022 Kept elements SHALL be compacted to the lowest indices in order; unused upper slots SHALL be 0; unique_count is the number kept (1..N).
REQ-023 Latency SHALL be fixed and independent of data: out_valid rises 2N edges after the acceptance edge with dedup_en=1, and N edges after it with dedup_en=0.
REQ-024 In DONE, out_data and unique_count SHALL hold stable while out_ready=0.
REQ-025 An edge in DONE with out_ready=1 SHALL complete the transfer and return the FSM to IDLE; in_ready=1 on the following cycle (no same-cycle re-accept).
REQ-026 in_valid and in_data SHALL be ignored outside IDLE; in_data and dedup_en changes after acceptance SHALL NOT affect the result.
REQ-027 Equal keys and the value 0 SHALL be handled correctly; an all-zero input gives out_data all 0 with unique_count 1 (dedup) or N (no dedup).
REQ-028 Maximum values (all ones) SHALL sort without overflow; comparisons are unsigned and DATA_W wide.

Reset
REQ-029 While rst_n=0 (asynchronously): FSM=IDLE, in_ready=1, out_valid=0, out_data=0, unique_count=0, and the working array cleared.
REQ-030 Reset asserted in SORT, DEDUP or DONE SHALL abort the operation with no partial result presented; after release the block is ready on the first edge.

Verification (N=9, DATA_W=8)
REQ-031 Input {5,3,9,3,1,9,7,5,2}, dedup_en=1 -> out {1,2,3,5,7,9,0,0,0}, unique_count=6, out_valid 18 edges after acceptance.
REQ-032 Same input, dedup_en=0 -> out {1,2,3,3,5,5,7,9,9}, unique_count=9, out_valid 9 edges after acceptance.
REQ-033 All elements 8'hFF, dedup_en=1 -> out {FF,0,0,0,0,0,0,0,0}, unique_count=1; all 0 -> out all 0, unique_count=1.
REQ-034 out_ready held 0 for 5 cycles in DONE while in_valid=1 with a new vector -> out_data stable, in_ready=0, new vector not taken; it is accepted only after the transfer plus one cycle.
REQ-035 rst_n pulsed low at SORT cycle 4 -> out_valid=0 and outputs 0 immediately; a fresh vector after release gives the correct result at the nominal latency.
REQ-036 Reverse-sorted input {8,7,6,5,4,3,2,1,0}, dedup_en=1 -> out {0,1,2,3,4,5,6,7,8}, unique_count=9 (worst-case sort distance).
